// File: rtl/uart_rx_framed.sv
// Parametrised UART receiver: majority-of-3 sampling, parity/framing flags,
// and a first-word-fall-through FIFO with valid/ready output and RTS.
module uart_rx_framed #(
  parameter int CLOCK_FREQ  = 50_000_000,
  parameter int BAUD_RATE   = 115_200,
  parameter int DATA_BITS   = 8,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                 sample_clock,
  input  logic                 reset,
  input  logic                 uart_rx,
  output logic                 uart_rts,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_overrun,
  output logic                 rx_busy
);

  localparam int DIVISOR = CLOCK_FREQ / BAUD_RATE;
  localparam int HALF    = DIVISOR / 2;
  localparam int CNT_W   = $clog2(DIVISOR);
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_F_W = PTR_W + 1;
  localparam int ENTRY_W = DATA_BITS + 2;

  generate
    if (DIVISOR < 8) begin : g_bad_divisor
      $error("uart_rx_framed: CLOCK_FREQ / BAUD_RATE must be at least 8");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
      $error("uart_rx_framed: DATA_BITS must be 5..9");
    end
    if (PARITY_MODE < 0 || PARITY_MODE > 2) begin : g_bad_parity
      $error("uart_rx_framed: PARITY_MODE must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
      $error("uart_rx_framed: STOP_BITS must be 1 or 2");
    end
    if (FIFO_DEPTH < 2 || (1 << PTR_W) != FIFO_DEPTH) begin : g_bad_depth
      $error("uart_rx_framed: FIFO_DEPTH must be a power of two, at least 2");
    end
  endgenerate

  // IDLE wait edge | START check start bit | DATA shift bits | PARITY check
  // STOP check stop bits, push | WAIT_HIGH hold off until line returns high
  typedef enum logic [2:0] {
    ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP, ST_WAIT_HIGH
  } state_t;

  state_t state, state_next;

  logic                 sync_q1, s_rx, prev_rx;
  logic [CNT_W-1:0]     cnt;
  logic [3:0]           bit_idx;
  logic                 stop_idx;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 samp0, samp1;
  logic                 parity_err_q, frame_err_q;

  logic fall_edge, at_s0, at_s1, decide, majority;
  logic last_data, last_stop, frame_err_now, parity_bad;
  logic push_req;

  always_ff @(posedge sample_clock or posedge reset) begin
    if (reset) begin
      sync_q1 <= 1'b1;
      s_rx    <= 1'b1;
      prev_rx <= 1'b1;
    end else begin
      sync_q1 <= uart_rx;
      s_rx    <= sync_q1;
      prev_rx <= s_rx;
    end
  end

  assign fall_edge     = prev_rx & ~s_rx;
  assign at_s0         = (cnt == CNT_W'(HALF - 1));
  assign at_s1         = (cnt == CNT_W'(HALF));
  assign decide        = (cnt == CNT_W'(HALF + 1));
  assign majority      = (samp0 & samp1) | (samp0 & s_rx) | (samp1 & s_rx);
  assign last_data     = (bit_idx == 4'(DATA_BITS - 1));
  assign last_stop     = (stop_idx == 1'(STOP_BITS - 1));
  assign frame_err_now = frame_err_q | ~majority;
  assign parity_bad    = (PARITY_MODE == 2) ? ~((^shift_reg) ^ majority)
                                            :  ((^shift_reg) ^ majority);

  always_ff @(posedge sample_clock or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    push_req   = 1'b0;
    case (state)
      ST_IDLE:   if (fall_edge) state_next = ST_START;
      ST_START:  if (decide) state_next = majority ? ST_IDLE : ST_DATA;
      ST_DATA:   if (decide && last_data)
                   state_next = (PARITY_MODE != 0) ? ST_PARITY : ST_STOP;
      ST_PARITY: if (decide) state_next = ST_STOP;
      ST_STOP: begin
        if (decide && last_stop) begin
          push_req   = 1'b1;
          state_next = frame_err_now ? ST_WAIT_HIGH : ST_IDLE;
        end
      end
      ST_WAIT_HIGH: if (s_rx) state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // The bit counter free-runs through the whole frame so each decision lands
  // exactly one DIVISOR after the previous one.
  always_ff @(posedge sample_clock or posedge reset) begin
    if (reset) begin
      cnt          <= '0;
      bit_idx      <= '0;
      stop_idx     <= 1'b0;
      shift_reg    <= '0;
      samp0        <= 1'b1;
      samp1        <= 1'b1;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else if (state == ST_IDLE) begin
      cnt          <= '0;
      bit_idx      <= '0;
      stop_idx     <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      cnt <= (cnt == CNT_W'(DIVISOR - 1)) ? '0 : cnt + CNT_W'(1);
      if (at_s0) samp0 <= s_rx;
      if (at_s1) samp1 <= s_rx;
      if (decide) begin
        case (state)
          ST_DATA: begin
            shift_reg <= {majority, shift_reg[DATA_BITS-1:1]};
            bit_idx   <= bit_idx + 4'd1;
          end
          ST_PARITY: parity_err_q <= parity_bad;
          ST_STOP: begin
            frame_err_q <= frame_err_now;
            stop_idx    <= stop_idx + 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_F_W-1:0] count;
  logic [ENTRY_W-1:0] push_entry, head;
  logic               full, pop, push_ok;

  assign push_entry = {frame_err_now, parity_err_q, shift_reg};
  assign full       = (count == CNT_F_W'(FIFO_DEPTH));
  assign rx_valid   = (count != '0);
  assign pop        = rx_valid & rx_ready;
  assign push_ok    = push_req & (~full | pop);
  assign rx_overrun = push_req & ~push_ok;
  assign rx_busy    = (state != ST_IDLE);

  // When full with a simultaneous pop, wr_ptr == rd_ptr: the head is read
  // combinationally this cycle before the slot is overwritten at the edge.
  always_ff @(posedge sample_clock) begin
    if (push_ok) mem[wr_ptr] <= push_entry;
  end

  always_ff @(posedge sample_clock or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      uart_rts <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + CNT_F_W'(1);
        2'b01:   count <= count - CNT_F_W'(1);
        default: count <= count;
      endcase
      uart_rts <= (count >= CNT_F_W'(FIFO_DEPTH - 1));
    end
  end

  assign head          = mem[rd_ptr];
  assign rx_data       = rx_valid ? head[DATA_BITS-1:0] : '0;
  assign rx_parity_err = rx_valid & head[DATA_BITS];
  assign rx_frame_err  = rx_valid & head[DATA_BITS+1];

endmodule

// File: tb/tb_uart_rx_framed.sv
// Bench for uart_rx_framed: an 8N1 and an 8E1 instance at DIVISOR 16, checked
// against frame-level expectation queues plus directed literal checks.
module tb_uart_rx_framed;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic line_n = 1'b1, line_e = 1'b1;
  logic ready_n = 1'b0, ready_e = 1'b0;

  logic       rts_n, par_n, fe_n, valid_n, ovr_n, busy_n;
  logic       rts_e, par_e, fe_e, valid_e, ovr_e, busy_e;
  logic [7:0] data_n, data_e;

  always #5 clk = ~clk;

  uart_rx_framed #(.CLOCK_FREQ(1_000_000), .BAUD_RATE(62_500), .DATA_BITS(8),
                   .PARITY_MODE(0), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_n (
    .sample_clock(clk), .reset(rst), .uart_rx(line_n), .uart_rts(rts_n),
    .rx_data(data_n), .rx_parity_err(par_n), .rx_frame_err(fe_n),
    .rx_valid(valid_n), .rx_ready(ready_n), .rx_overrun(ovr_n), .rx_busy(busy_n));

  uart_rx_framed #(.CLOCK_FREQ(1_000_000), .BAUD_RATE(62_500), .DATA_BITS(8),
                   .PARITY_MODE(1), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_e (
    .sample_clock(clk), .reset(rst), .uart_rx(line_e), .uart_rts(rts_e),
    .rx_data(data_e), .rx_parity_err(par_e), .rx_frame_err(fe_e),
    .rx_valid(valid_e), .rx_ready(ready_e), .rx_overrun(ovr_e), .rx_busy(busy_e));

  int checks = 0;
  int errors = 0;
  logic [9:0] exp_n[$], exp_e[$];   // {frame_err, parity_err, data}
  int ovr_seen[2] = '{0, 0};
  int ovr_exp[2]  = '{0, 0};
  int pops[2]     = '{0, 0};
  bit rand_rdy    = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Head of each FIFO must always equal the oldest outstanding expected frame.
  always @(negedge clk) begin
    if (!rst) begin
      if (valid_n) begin
        if (exp_n.size() == 0) chk("n_spurious_entry", {fe_n, par_n, data_n}, 32'hFFFF);
        else begin
          chk("n_head", {fe_n, par_n, data_n}, exp_n[0]);
          if (ready_n) begin void'(exp_n.pop_front()); pops[0]++; end
        end
      end
      if (valid_e) begin
        if (exp_e.size() == 0) chk("e_spurious_entry", {fe_e, par_e, data_e}, 32'hFFFF);
        else begin
          chk("e_head", {fe_e, par_e, data_e}, exp_e[0]);
          if (ready_e) begin void'(exp_e.pop_front()); pops[1]++; end
        end
      end
      if (ovr_n) ovr_seen[0]++;
      if (ovr_e) ovr_seen[1]++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_rdy) begin
      ready_n = 1'($urandom_range(0, 1));
      ready_e = 1'($urandom_range(0, 1));
    end
  endtask

  // Expected entry from the frame-level rules: even parity error when the
  // XOR of data and parity bit is 1; frame error when the stop bit is 0.
  task automatic expect_frame(input int d, input logic [7:0] data, input logic pbit,
                              input logic stop_val, input bit drop);
    logic [9:0] ent;
    ent = {~stop_val, (d == 1) ? ((^data) ^ pbit) : 1'b0, data};
    if (drop) ovr_exp[d]++;
    else if (d == 0) exp_n.push_back(ent);
    else exp_e.push_back(ent);
  endtask

  task automatic send_frame(input int d, input logic [7:0] data, input logic pbit,
                            input logic stop_val, input int pop_at);
    logic bits [12];
    int nb;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[1+i] = data[i];
    if (d == 1) begin bits[9] = pbit; bits[10] = stop_val; nb = 11; end
    else begin bits[9] = stop_val; nb = 10; end
    for (int c = 0; c < nb * 16; c++) begin
      if (d == 0) line_n = bits[c/16]; else line_e = bits[c/16];
      if (c == pop_at) ready_n = 1'b1;
      else if (c == pop_at + 1) ready_n = 1'b0;
      tick();
    end
    if (d == 0) line_n = 1'b1; else line_e = 1'b1;
  endtask

  task automatic drain(input int d);
    int to;
    to = 1;
    if (d == 0) ready_n = 1'b1; else ready_e = 1'b1;
    for (int i = 0; i < 60; i++) begin
      tick();
      if ((d == 0 && !valid_n) || (d == 1 && !valid_e)) begin to = 0; break; end
    end
    if (d == 0) ready_n = 1'b0; else ready_e = 1'b0;
    chk("drain_timeout", to, 0);
    chk("model_queue_empty", (d == 0) ? exp_n.size() : exp_e.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, p0;
    logic [7:0] rd;
    logic pb, sb;
    int gap;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_valid", valid_n, 0);
    chk("reset_rts", rts_n, 0);
    chk("reset_busy", busy_n, 0);
    chk("reset_data", data_n, 0);
    chk("reset_overrun", ovr_n, 0);
    rst = 1'b0;
    repeat (4) tick();

    // 8N1 back-to-back 0xA5, 0x3C; valid rises 157 edges after the start bit
    expect_frame(0, 8'hA5, 1'b0, 1'b1, 0);
    expect_frame(0, 8'h3C, 1'b0, 1'b1, 0);
    lat = -1;
    fork
      begin
        send_frame(0, 8'hA5, 1'b0, 1'b1, -10);
        send_frame(0, 8'h3C, 1'b0, 1'b1, -10);
      end
      begin
        for (int i = 1; i <= 400; i++) begin
          @(negedge clk);
          if (valid_n) begin lat = i; break; end
        end
      end
    join
    repeat (20) tick();
    chk("valid_latency", lat, 158);
    chk("a5_data", data_n, 8'hA5);
    chk("a5_flags", {fe_n, par_n}, 0);
    p0 = pops[0];
    drain(0);
    chk("two_entries_popped", pops[0] - p0, 2);

    // 8E1 parity good then bad
    expect_frame(1, 8'h07, 1'b1, 1'b1, 0);
    send_frame(1, 8'h07, 1'b1, 1'b1, -10);
    expect_frame(1, 8'h07, 1'b0, 1'b1, 0);
    send_frame(1, 8'h07, 1'b0, 1'b1, -10);
    repeat (20) tick();
    chk("e_good_parity", {par_e, data_e}, 9'h007);
    ready_e = 1'b1;
    tick();
    ready_e = 1'b0;
    chk("e_bad_parity", {par_e, fe_e, data_e}, 10'h207);
    drain(1);

    // 4-cycle glitch: false start, nothing pushed
    line_n = 1'b0;
    repeat (4) tick();
    line_n = 1'b1;
    tick();
    chk("glitch_busy_seen", busy_n, 1);
    repeat (11) tick();
    chk("glitch_busy_cleared", busy_n, 0);
    chk("glitch_no_push", valid_n, 0);
    repeat (16) tick();

    // Break: 3 frame times low -> one entry, data 0, frame error
    expect_frame(0, 8'h00, 1'b0, 1'b0, 0);
    line_n = 1'b0;
    repeat (480) tick();
    line_n = 1'b1;
    repeat (40) tick();
    chk("break_entry", {valid_n, fe_n, par_n, data_n}, 11'h600);
    p0 = pops[0];
    drain(0);
    chk("break_single_entry", pops[0] - p0, 1);
    expect_frame(0, 8'h55, 1'b0, 1'b1, 0);
    send_frame(0, 8'h55, 1'b0, 1'b1, -10);
    repeat (10) tick();
    chk("after_break_data", {fe_n, data_n}, 9'h055);
    drain(0);

    // FIFO fill with consumer stalled; RTS and overrun
    for (int f = 0; f < 5; f++) begin
      rd = 8'(8'h11 * (f + 1));
      expect_frame(0, rd, 1'b0, 1'b1, exp_n.size() >= 4);
      send_frame(0, rd, 1'b0, 1'b1, -10);
      repeat (4) tick();
      if (f == 1) chk("rts_after_2", rts_n, 0);
      if (f == 2) chk("rts_after_3", rts_n, 1);
      if (f == 3) chk("no_overrun_at_4", ovr_seen[0], 0);
    end
    chk("overrun_once", ovr_seen[0], 1);
    chk("full_head", data_n, 8'h11);
    // Push while full, coinciding with a pop, must be accepted
    expect_frame(0, 8'h66, 1'b0, 1'b1, 0);
    send_frame(0, 8'h66, 1'b0, 1'b1, 156);
    repeat (4) tick();
    chk("coincide_no_overrun", ovr_seen[0], 1);
    chk("coincide_head", data_n, 8'h22);
    p0 = pops[0];
    drain(0);
    chk("coincide_remaining", pops[0] - p0, 4);
    repeat (3) tick();
    chk("rts_after_drain", rts_n, 0);

    // Reset halfway through a frame with one entry held
    expect_frame(0, 8'h5A, 1'b0, 1'b1, 0);
    send_frame(0, 8'h5A, 1'b0, 1'b1, -10);
    repeat (4) tick();
    fork
      send_frame(0, 8'hC3, 1'b0, 1'b1, -10);
      begin
        repeat (80) @(posedge clk);
        #1;
        chk("pre_reset_busy", busy_n, 1);
        chk("pre_reset_valid", valid_n, 1);
        #1;
        rst = 1'b1;
        exp_n.delete();
        exp_e.delete();
        #1;
        chk("mid_reset_outputs", {valid_n, busy_n, rts_n, fe_n, par_n, ovr_n}, 0);
        chk("mid_reset_data", data_n, 0);
      end
    join
    tick();
    rst = 1'b0;
    repeat (20) tick();
    expect_frame(0, 8'h96, 1'b0, 1'b1, 0);
    send_frame(0, 8'h96, 1'b0, 1'b1, -10);
    repeat (4) tick();
    chk("post_reset_data", {valid_n, fe_n, data_n}, 10'h296);
    drain(0);

    // Randomised frames on both links with a random consumer
    ovr_seen = '{0, 0};
    ovr_exp  = '{0, 0};
    rand_rdy = 1'b1;
    for (int r = 0; r < 40; r++) begin
      for (int d = 0; d < 2; d++) begin
        rd  = 8'($urandom);
        pb  = 1'($urandom_range(0, 1));
        sb  = ($urandom_range(0, 5) != 0);
        gap = sb ? int'($urandom_range(0, 10)) : 8 + int'($urandom_range(0, 10));
        expect_frame(d, rd, pb, sb, 0);
        send_frame(d, rd, pb, sb, -10);
        repeat (gap) tick();
      end
    end
    rand_rdy = 1'b0;
    repeat (20) tick();
    drain(0);
    drain(1);
    chk("rand_overrun_n", ovr_seen[0], ovr_exp[0]);
    chk("rand_overrun_e", ovr_seen[1], ovr_exp[1]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_framed.md
# uart_rx_framed

Parametrised UART receiver that replaces the fixed 8N1 receiver in the diagnostics link. Characteristics:
- Configurable data width, parity and stop bits.
- Majority-of-3 sampling per bit and false-start rejection.
- Per-frame parity and framing error flags.
- Small first-word-fall-through FIFO with valid/ready output and RTS flow control.

It sits between the board RX pin and the command decoder.

## Interface
- CLOCK_FREQ, 50_000_000, sample_clock frequency in Hz
- BAUD_RATE, 115_200, line rate; DIVISOR = CLOCK_FREQ / BAUD_RATE (integer divide), HALF = DIVISOR / 2; elaboration error if DIVISOR < 8
- DATA_BITS, 8, data bits per frame, legal 5..9, sent LSB first
- PARITY_MODE, 0, 0 = none, 1 = even, 2 = odd
- STOP_BITS, 1, legal 1 or 2
- FIFO_DEPTH, 4, entries, power of two, at least 2

Ports:
- sample_clock  in  1  the only clock
- reset  in  1  asynchronous, active-high; all state clears immediately on assertion
- uart_rx  in  1  serial line, idle high, asynchronous to sample_clock
- uart_rts  out  1  1 = stop sending, 0 = ready
- rx_data  out  DATA_BITS  data at the FIFO head
- rx_parity_err  out  1  parity flag of the head entry; always 0 when PARITY_MODE = 0
- rx_frame_err  out  1  framing flag of the head entry (a stop bit was sampled 0)
- rx_valid  out  1  FIFO not empty
- rx_ready  in  1  consumer accepts the head entry
- rx_overrun  out  1  one-cycle pulse when a completed frame is dropped
- rx_busy  out  1  FSM is not in IDLE

## Operation
- Input path:
  - uart_rx passes through a 2-flop synchroniser; both flops reset to 1.
  - All logic below uses the synchronised value, s_rx.
- Bit timing:
  - A counter runs 0..DIVISOR-1 within each bit period.
  - Samples are taken at counts HALF-1, HALF and HALF+1.
  - The bit value is the majority of the 3 samples, decided at count HALF+1.
- States:
  - IDLE: wait for a falling edge on s_rx (previous 1, current 0). On the edge, counter <= 0 and go to START.
  - START: decide the start bit. Majority 1 means a false start: go to IDLE, push nothing. Majority 0: go to DATA.
  - DATA: shift in DATA_BITS bits, LSB first. Then go to PARITY if PARITY_MODE != 0, otherwise go to STOP.
  - PARITY: even parity error = XOR(data, parity bit) != 0. Odd parity error = that XOR == 0.
  - STOP: sample STOP_BITS bits. Any stop bit with majority 0 sets frame_err. At the decision point of the last stop bit, push {frame_err, parity_err, data}. Then go to IDLE if frame_err = 0, otherwise go to WAIT_HIGH.
  - WAIT_HIGH: stay until s_rx = 1, then go to IDLE. A break (line held low) therefore yields exactly one entry, with data 0 and frame_err = 1.
- FIFO:
  - Output is first-word-fall-through: rx_valid = not empty, and the head entry drives rx_data and both error flags.
  - A pop happens when rx_valid && rx_ready.
  - A push is accepted when the FIFO is not full, or when it is full and a pop occurs in the same cycle.
  - Otherwise the frame is dropped and rx_overrun pulses for one cycle.
  - Read and write pointers wrap modulo FIFO_DEPTH. The count is held in a $clog2(FIFO_DEPTH)+1-bit register.
- Flow control: uart_rts = 1 when count >= FIFO_DEPTH-1, otherwise 0. RTS has no effect on the receiver, which continues to accept frames.
- Reset values:
  - uart_rts = 0, rx_valid = 0, rx_data = 0, both error flags = 0, rx_overrun = 0, rx_busy = 0.
  - FIFO is empty and the FSM is in IDLE.
- Reset asserted mid-frame discards the partial frame and all FIFO contents.

## Timing
- A falling edge on uart_rx reaches s_rx 2-3 cycles later. Bit decisions are then made at the edge cycle + k*DIVISOR + HALF+1, where k = 0 is the start bit.
- Push occurs in the decision cycle of the last stop bit. rx_valid rises in the next cycle when the FIFO was empty.
- IDLE is re-entered about half a bit before the line's nominal stop-bit end. Back-to-back frames with no idle gap must therefore be received.
- Pop is registered: the next head entry, or rx_valid = 0, is presented in the cycle after the handshake.
- rx_overrun is high only in the dropped push cycle.
- uart_rts updates in the cycle after a count change.

## Test plan
- DIVISOR = 16 (CLOCK_FREQ = 1_000_000, BAUD_RATE = 62_500), 8N1: send 0xA5 then 0x3C back-to-back -> two entries 0xA5 and 0x3C, no error flags, rx_valid set 1 cycle after each push.
- 8E1: send 0x07 with parity 1 -> parity_err = 0. Send 0x07 with parity 0 -> parity_err = 1, data 0x07.
- Glitch: low pulse of 4 cycles on uart_rx -> no push, FSM back in IDLE, rx_busy low within 16 cycles.
- Break: line held low for 3 frame times -> exactly one entry with data 0x00 and frame_err = 1; next frame 0x55 after the line returns high is received correctly.
- FIFO_DEPTH = 4, rx_ready = 0: send 5 frames -> uart_rts = 1 after the 3rd, 4 entries held, rx_overrun pulses once on the 5th. Push coinciding with a pop while full -> accepted, no overrun.
- Assert reset halfway through a frame -> all outputs take reset values immediately; a frame sent after deassertion decodes correctly.
